// File: rtl/trigger_chain_cfg_sequencer.sv
// Wishbone master replaying a host-loaded table of {adr, dat} writes onto the trigger chain
// config bus, with bounded retries, per-transaction timeout and host abort.
`timescale 1ns/1ps
module trigger_chain_cfg_sequencer #(
  parameter int unsigned DEPTH_BITS     = 6,
  parameter int unsigned ADDR_W         = 22,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     tbl_we_i,
  input  logic [DEPTH_BITS-1:0]    tbl_addr_i,
  input  logic [ADDR_W+DATA_W-1:0] tbl_dat_i,
  input  logic [DEPTH_BITS:0]      count_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [2:0]               err_code_o,
  output logic [DEPTH_BITS-1:0]    err_idx_o,
  output logic                     wb_m_cyc_o,
  output logic                     wb_m_stb_o,
  output logic                     wb_m_we_o,
  output logic [ADDR_W-1:0]        wb_m_adr_o,
  output logic [DATA_W-1:0]        wb_m_dat_o,
  output logic [DATA_W/8-1:0]      wb_m_sel_o,
  input  logic                     wb_m_ack_i,
  input  logic                     wb_m_err_i,
  input  logic                     wb_m_rty_i
);

  localparam int unsigned ENTRIES = 2 ** DEPTH_BITS;
  localparam int unsigned SEL_W   = DATA_W / 8;
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0]  RETRY_LIM  = RETRY_W'(MAX_RETRY);
  localparam logic [7:0]          TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [DEPTH_BITS:0] COUNT_MAX  = (DEPTH_BITS + 1)'(ENTRIES);

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_BUS_ERR = 3'd1;
  localparam logic [2:0] CODE_RETRY   = 3'd2;
  localparam logic [2:0] CODE_TIMEOUT = 3'd3;
  localparam logic [2:0] CODE_ABORT   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_BACKOFF,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [ADDR_W+DATA_W-1:0] mem [ENTRIES];
  logic [DEPTH_BITS-1:0]    idx, last_idx;
  logic [RETRY_W-1:0]       retry;
  logic [7:0]               timer;
  logic [DEPTH_BITS:0]      count_clamped;
  logic [2:0]               fail_code;
  logic start_go, active, take_abort, in_req;
  logic req_err, req_rty, req_ack, req_tmo, last_entry, retry_out;

  // Response decode; abort outranks every bus response, then err > rty > ack > timeout.
  assign start_go      = (state == S_IDLE) && start_i;
  assign active        = (state == S_FETCH) || (state == S_REQ) || (state == S_BACKOFF);
  assign take_abort    = active && abort_i;
  assign in_req        = (state == S_REQ) && !take_abort;
  assign req_err       = in_req && wb_m_err_i;
  assign req_rty       = in_req && !wb_m_err_i && wb_m_rty_i;
  assign req_ack       = in_req && !wb_m_err_i && !wb_m_rty_i && wb_m_ack_i;
  assign req_tmo       = in_req && !wb_m_err_i && !wb_m_rty_i && !wb_m_ack_i &&
                         (timer == TIMER_LAST);
  assign last_entry    = (idx == last_idx);
  assign retry_out     = (retry == RETRY_LIM);
  assign count_clamped = (count_i > COUNT_MAX) ? COUNT_MAX : count_i;

  always_ff @(posedge wb_clk_i) begin
    if (tbl_we_i) mem[tbl_addr_i] <= tbl_dat_i;
  end

  // Read port only loads in FETCH so adr/dat stay stable across REQ/BACKOFF.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_m_adr_o <= '0;
      wb_m_dat_o <= '0;
    end else if (state == S_FETCH) begin
      {wb_m_adr_o, wb_m_dat_o} <= mem[idx];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      idx      <= '0;
      last_idx <= '0;
      retry    <= '0;
      timer    <= '0;
    end else begin
      if (start_go) begin
        idx      <= '0;
        last_idx <= DEPTH_BITS'(count_clamped - (DEPTH_BITS + 1)'(1));
        retry    <= '0;
      end
      if (req_ack) begin
        retry <= '0;
        if (!last_entry) idx <= idx + 1'b1;
      end
      if (req_rty && !retry_out) retry <= retry + 1'b1;
      timer <= (state == S_REQ) ? timer + 1'b1 : '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start_i) next_state = (count_i == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH:   next_state = take_abort ? S_DONE : S_REQ;
      S_REQ: begin
        if (take_abort || req_err || req_tmo || (req_rty && retry_out) ||
            (req_ack && last_entry))
          next_state = S_DONE;
        else if (req_rty)
          next_state = S_BACKOFF;
        else if (req_ack)
          next_state = S_FETCH;
      end
      S_BACKOFF: next_state = take_abort ? S_DONE : S_REQ;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    fail_code = CODE_NONE;
    if (take_abort)                fail_code = CODE_ABORT;
    else if (req_err)              fail_code = CODE_BUS_ERR;
    else if (req_rty && retry_out) fail_code = CODE_RETRY;
    else if (req_tmo)              fail_code = CODE_TIMEOUT;
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      wb_m_cyc_o <= 1'b0;
      wb_m_stb_o <= 1'b0;
      wb_m_we_o  <= 1'b0;
      wb_m_sel_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      err_code_o <= '0;
      err_idx_o  <= '0;
    end else begin
      state      <= next_state;
      wb_m_cyc_o <= (next_state == S_REQ);
      wb_m_stb_o <= (next_state == S_REQ);
      wb_m_we_o  <= (next_state == S_REQ);
      wb_m_sel_o <= {SEL_W{next_state == S_REQ}};
      busy_o     <= (next_state == S_FETCH) || (next_state == S_REQ) ||
                    (next_state == S_BACKOFF);
      done_o     <= (next_state == S_DONE);
      if (start_go) begin
        error_o    <= 1'b0;
        err_code_o <= CODE_NONE;
        err_idx_o  <= '0;
      end else if (fail_code != CODE_NONE) begin
        error_o    <= 1'b1;
        err_code_o <= fail_code;
        err_idx_o  <= idx;
      end
    end
  end

endmodule
